// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the fetch/load-store RAM arbiter.
package mem_arb_pkg;

    localparam int N = 32;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_MERGE = 1'b1;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    function automatic int addr_bits(input int size);
        return $clog2(size);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between core ports, arbiter and the single-port RAM.
interface mem_arbiter_if #(parameter int A = 10);
    import mem_arb_pkg::*;

    logic          if_req;
    logic [A-1:0]  if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [N-1:0]  if_rdata;

    logic          d_req;
    logic          d_we;
    logic [1:0]    d_size;
    logic [A-1:0]  d_addr;
    logic [N-1:0]  d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [N-1:0]  d_rdata;

    logic          ram_we;
    logic [A-1:0]  ram_addr;
    logic [N-1:0]  ram_wdata;
    logic [N-1:0]  ram_rdata;

    modport master (
        output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, ram_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               ram_we, ram_addr, ram_wdata
    );

    modport ram (
        input  ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/mem_arbiter_store_merge.sv
// Byte-lane merge of right-aligned store data into an old RAM word.
module store_merge
    import mem_arb_pkg::*;
(
    input  logic [N-1:0] i_old,
    input  logic [N-1:0] i_wdata,
    input  logic [1:0]   i_size,
    input  logic [1:0]   i_lane,
    output logic [N-1:0] o_merged
);

    always_comb begin
        o_merged = i_old;
        case (i_size)
            SZ_B: o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
            // Halfword lane comes from addr[1] only; addr[0] is ignored.
            SZ_H: o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
            default: o_merged = i_wdata;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter for a single-port word RAM with RMW sub-word stores.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data port has fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int SIZE = 1024
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    localparam int A = addr_bits(SIZE);

    logic [0:0]   r_state;
    logic [A-1:0] r_maddr;
    logic [N-1:0] r_mdata;
    logic         r_if_rvalid;
    logic         r_d_rvalid;
    logic [N-1:0] r_if_rdata;
    logic [N-1:0] r_d_rdata;

    logic         w_idle;
    logic         w_d_win;
    logic         w_if_win;
    logic         w_is_word;
    logic [A-1:0] w_d_waddr;
    logic [A-1:0] w_if_waddr;
    logic [N-1:0] w_merged;

`ifdef MEM_ARB_RR_EN
    logic r_ptr;
`endif

    assign w_is_word  = bus.d_size[1];  // 2'b11 behaves as a word access
    assign w_d_waddr  = bus.d_addr  & ~A'(3);
    assign w_if_waddr = bus.if_addr & ~A'(3);

    store_merge u_merge (
        .i_old    (bus.ram_rdata),
        .i_wdata  (bus.d_wdata),
        .i_size   (bus.d_size),
        .i_lane   (bus.d_addr[1:0]),
        .o_merged (w_merged)
    );

    always_comb begin
        w_idle = (r_state == ST_IDLE) && !rst;
`ifdef MEM_ARB_RR_EN
        w_d_win = w_idle && bus.d_req && (!bus.if_req || r_ptr == OWN_D);
`else
        w_d_win = w_idle && bus.d_req;
`endif
        w_if_win = w_idle && bus.if_req && !w_d_win;
    end

    always_comb begin
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (r_state == ST_MERGE && !rst) begin
            bus.ram_we    = 1'b1;
            bus.ram_addr  = r_maddr;
            bus.ram_wdata = r_mdata;
        end else if (w_d_win) begin
            bus.ram_addr = w_d_waddr;
            if (bus.d_we && w_is_word) begin
                bus.ram_we    = 1'b1;
                bus.ram_wdata = bus.d_wdata;
            end
        end else if (w_if_win) begin
            bus.ram_addr = w_if_waddr;
        end
    end

    assign bus.if_gnt    = w_if_win;
    assign bus.d_gnt     = w_d_win;
    assign bus.if_rvalid = r_if_rvalid;
    assign bus.d_rvalid  = r_d_rvalid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rdata   = r_d_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_maddr     <= '0;
            r_mdata     <= '0;
`ifdef MEM_ARB_RR_EN
            r_ptr       <= OWN_D;
`endif
        end else begin
            r_if_rvalid <= w_if_win;
            r_d_rvalid  <= 1'b0;
            if (w_if_win)
                r_if_rdata <= bus.ram_rdata;
            if (r_state == ST_MERGE) begin
                r_d_rvalid <= 1'b1;
                r_d_rdata  <= '0;
                r_state    <= ST_IDLE;
            end else if (w_d_win) begin
                if (!bus.d_we) begin
                    r_d_rvalid <= 1'b1;
                    r_d_rdata  <= bus.ram_rdata;
                end else if (w_is_word) begin
                    r_d_rvalid <= 1'b1;
                    r_d_rdata  <= '0;
                end else begin
                    // Old word is on ram_rdata now; write the merged word next cycle.
                    r_maddr <= w_d_waddr;
                    r_mdata <= w_merged;
                    r_state <= ST_MERGE;
                end
            end
`ifdef MEM_ARB_RR_EN
            if (w_d_win)
                r_ptr <= OWN_IF;
            else if (w_if_win)
                r_ptr <= OWN_D;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural word RAM.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic        tb_we;
    logic [7:0]  tb_widx;
    logic [31:0] tb_wdat;
    logic [31:0] mem [0:255];

    mem_arbiter_if #(.A(10)) bus ();

    mem_arbiter #(.SIZE(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.ram_rdata = mem[bus.ram_addr[9:2]];

    always @(posedge clk) begin
        if (tb_we)
            mem[tb_widx] <= tb_wdat;
        else if (bus.ram_we)
            mem[bus.ram_addr[9:2]] <= bus.ram_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic poke(input logic [7:0] idx, input logic [31:0] dat);
        tb_we   = 1'b1;
        tb_widx = idx;
        tb_wdat = dat;
        step();
        tb_we   = 1'b0;
    endtask

    task automatic set_d(input logic req, input logic we, input logic [1:0] sz,
                         input logic [9:0] addr, input logic [31:0] wd);
        bus.d_req   = req;
        bus.d_we    = we;
        bus.d_size  = sz;
        bus.d_addr  = addr;
        bus.d_wdata = wd;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        tb_we       = 1'b0;
        tb_widx     = '0;
        tb_wdat     = '0;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        set_d(1'b0, 1'b0, SZ_W, 10'h000, 32'h0);

        poke(8'd0,  32'h0000_0000);
        poke(8'd4,  32'hDEAD_BEEF);
        poke(8'd8,  32'h1122_3344);
        poke(8'd16, 32'h0000_0000);

        // Reset held two cycles with both ports requesting
        bus.if_req  = 1'b1;
        bus.if_addr = 10'h010;
        set_d(1'b1, 1'b0, SZ_W, 10'h000, 32'h0);
        for (int i = 0; i < 2; i++) begin
            samp();
            chk("rst_d_gnt",    32'(bus.d_gnt),     32'h0);
            chk("rst_if_gnt",   32'(bus.if_gnt),    32'h0);
            chk("rst_ram_we",   32'(bus.ram_we),    32'h0);
            chk("rst_d_rvalid", 32'(bus.d_rvalid),  32'h0);
            chk("rst_if_rvalid",32'(bus.if_rvalid), 32'h0);
            chk("rst_ram_addr", 32'(bus.ram_addr),  32'h0);
            chk("rst_if_rdata", bus.if_rdata,       32'h0);
            step();
        end
        rst = 1'b0;
        samp();
        chk("first_d_gnt",  32'(bus.d_gnt),  32'h1);
        chk("first_if_gnt", 32'(bus.if_gnt), 32'h0);
        step();
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        samp();
        chk("first_d_rvalid", 32'(bus.d_rvalid), 32'h1);

        // Fetch with unaligned address
        step();
        bus.if_req  = 1'b1;
        bus.if_addr = 10'h012;
        samp();
        chk("fetch_gnt",  32'(bus.if_gnt),   32'h1);
        chk("fetch_addr", 32'(bus.ram_addr), 32'h010);
        step();
        bus.if_req = 1'b0;
        samp();
        chk("fetch_rvalid", 32'(bus.if_rvalid), 32'h1);
        chk("fetch_rdata",  bus.if_rdata,       32'hDEAD_BEEF);
        step();
        samp();
        chk("fetch_rvalid_pulse", 32'(bus.if_rvalid), 32'h0);
        chk("fetch_rdata_hold",   bus.if_rdata,       32'hDEAD_BEEF);

        // Byte store at lane 1 with a competing fetch
        step();
        set_d(1'b1, 1'b1, SZ_B, 10'h021, 32'h0000_00AB);
        bus.if_req  = 1'b1;
        bus.if_addr = 10'h010;
        samp();
        chk("bst_d_gnt",  32'(bus.d_gnt),  32'h1);
        chk("bst_if_gnt", 32'(bus.if_gnt), 32'h0);
        chk("bst_no_we",  32'(bus.ram_we), 32'h0);
        step();
        bus.d_req = 1'b0;
        samp();
        chk("bst_we",       32'(bus.ram_we),    32'h1);
        chk("bst_addr",     32'(bus.ram_addr),  32'h020);
        chk("bst_wdata",    bus.ram_wdata,      32'h1122_AB44);
        chk("bst_if_block", 32'(bus.if_gnt),    32'h0);
        chk("bst_no_ack",   32'(bus.d_rvalid),  32'h0);
        step();
        samp();
        chk("bst_ack",       32'(bus.d_rvalid), 32'h1);
        chk("bst_ack_rdata", bus.d_rdata,       32'h0);
        chk("bst_if_gnt2",   32'(bus.if_gnt),   32'h1);
        step();
        bus.if_req = 1'b0;
        samp();
        chk("bst_if_rdata", bus.if_rdata, 32'hDEAD_BEEF);
        chk("bst_mem",      mem[8],       32'h1122_AB44);

        // Word store, load back, half store at upper lane, load back
        step();
        set_d(1'b1, 1'b1, SZ_W, 10'h040, 32'hCAFE_F00D);
        samp();
        chk("wst_gnt",   32'(bus.d_gnt),  32'h1);
        chk("wst_we",    32'(bus.ram_we), 32'h1);
        chk("wst_wdata", bus.ram_wdata,   32'hCAFE_F00D);
        step();
        bus.d_req = 1'b0;
        samp();
        chk("wst_ack", 32'(bus.d_rvalid), 32'h1);
        step();
        set_d(1'b1, 1'b0, SZ_W, 10'h040, 32'h0);
        samp();
        chk("wld_gnt", 32'(bus.d_gnt), 32'h1);
        step();
        bus.d_req = 1'b0;
        samp();
        chk("wld_rvalid", 32'(bus.d_rvalid), 32'h1);
        chk("wld_rdata",  bus.d_rdata,       32'hCAFE_F00D);
        step();
        set_d(1'b1, 1'b1, SZ_H, 10'h042, 32'h0000_BEEF);
        samp();
        chk("hst_gnt",   32'(bus.d_gnt),  32'h1);
        chk("hst_no_we", 32'(bus.ram_we), 32'h0);
        step();
        bus.d_req = 1'b0;
        samp();
        chk("hst_we",    32'(bus.ram_we),   32'h1);
        chk("hst_wdata", bus.ram_wdata,     32'hBEEF_F00D);
        chk("hst_addr",  32'(bus.ram_addr), 32'h040);
        step();
        samp();
        chk("hst_ack", 32'(bus.d_rvalid), 32'h1);
        step();
        set_d(1'b1, 1'b0, SZ_W, 10'h040, 32'h0);
        samp();
        step();
        bus.d_req = 1'b0;
        samp();
        chk("hld_rdata", bus.d_rdata, 32'hBEEF_F00D);

        // Both ports requesting word loads for six cycles after reset
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_d(1'b1, 1'b0, SZ_W, 10'h040, 32'h0);
        bus.if_req  = 1'b1;
        bus.if_addr = 10'h010;
        for (int i = 0; i < 6; i++) begin
            logic exp_d;
`ifdef MEM_ARB_RR_EN
            exp_d = (i % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            samp();
            chk($sformatf("arb_d_gnt_%0d", i),  32'(bus.d_gnt),  32'(exp_d));
            chk($sformatf("arb_if_gnt_%0d", i), 32'(bus.if_gnt), 32'(!exp_d));
            step();
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        step();

        // Reset during the merge write drops it; a retry completes
        set_d(1'b1, 1'b1, SZ_B, 10'h023, 32'h0000_0055);
        samp();
        chk("rmw_gnt", 32'(bus.d_gnt), 32'h1);
        step();
        rst       = 1'b1;
        bus.d_req = 1'b0;
        samp();
        chk("rmw_rst_we", 32'(bus.ram_we), 32'h0);
        step();
        rst = 1'b0;
        samp();
        chk("rmw_rst_ack", 32'(bus.d_rvalid), 32'h0);
        chk("rmw_rst_mem", mem[8],            32'h1122_AB44);
        step();
        bus.d_req = 1'b1;
        samp();
        chk("retry_gnt", 32'(bus.d_gnt), 32'h1);
        step();
        bus.d_req = 1'b0;
        samp();
        chk("retry_we",    32'(bus.ram_we), 32'h1);
        chk("retry_wdata", bus.ram_wdata,   32'h5522_AB44);
        step();
        samp();
        chk("retry_ack", 32'(bus.d_rvalid), 32'h1);
        chk("retry_mem", mem[8],            32'h5522_AB44);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
